instr_reg_ctrl: RTL and testbench

INSTR_REG_CTRL -- requirements
Module: instr_reg_ctrl

---
 rtl/instr_reg_ctrl.sv | 167 ++++++++++++++++
 tb/tb_instr_reg_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_reg_ctrl.sv
// Write/read controller for a 32-entry circular instruction register with a
// round-robin two-requester write port. Optional counters: INSTR_REG_CTRL_STATS_EN.
module instr_reg_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_opcode,
    input  logic [31:0] req0_op_a,
    input  logic [31:0] req0_op_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_opcode,
    input  logic [31:0] req1_op_a,
    input  logic [31:0] req1_op_b,
    input  logic        rd_valid,
    output logic        rd_ready,
    output logic        rd_data_valid,
    output logic [67:0] rd_data,
    output logic        load_en,
    output logic [4:0]  write_pointer,
    output logic [4:0]  read_pointer,
    output logic [3:0]  opcode,
    output logic [31:0] operand_a,
    output logic [31:0] operand_b,
    input  logic [67:0] instruction_word,
    input  logic        flush,
    output logic [15:0] stat_wr_cnt,
    output logic [15:0] stat_full_cnt
);

    localparam logic [5:0] DEPTH = 6'd32;

    logic [4:0]  r_wr_ptr;
    logic [4:0]  r_rd_ptr;
    logic [4:0]  r_wr_addr;
    logic [5:0]  r_alloc_cnt;
    logic [5:0]  r_commit_cnt;
    logic        r_prio;       // 0: req0 wins a tie, 1: req1 wins a tie
    logic        r_load_en;
    logic [3:0]  r_opcode;
    logic [31:0] r_operand_a;
    logic [31:0] r_operand_b;
    logic        r_rd_data_valid;
    logic [67:0] r_rd_data;

    logic        w_full;
    logic        w_tie;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_acc0;
    logic        w_acc1;
    logic        w_acc;
    logic        w_rd_acc;
    logic [3:0]  w_sel_opcode;
    logic [31:0] w_sel_op_a;
    logic [31:0] w_sel_op_b;

    // Full/empty come from pre-edge counts only: a same-cycle read never frees a slot.
    assign w_full   = (r_alloc_cnt == DEPTH);
    assign w_tie    = req0_valid && req1_valid;
    assign w_grant0 = req0_valid && (!req1_valid || !r_prio);
    assign w_grant1 = req1_valid && (!req0_valid ||  r_prio);

    assign req0_ready = w_grant0 && !w_full && !flush;
    assign req1_ready = w_grant1 && !w_full && !flush;
    assign w_acc0     = req0_valid && req0_ready;
    assign w_acc1     = req1_valid && req1_ready;
    assign w_acc      = w_acc0 || w_acc1;

    assign rd_ready   = (r_commit_cnt != 6'd0) && !flush;
    assign w_rd_acc   = rd_valid && rd_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_sel_opcode = req0_opcode;
        w_sel_op_a   = req0_op_a;
        w_sel_op_b   = req0_op_b;
        if (w_acc1) begin
            w_sel_opcode = req1_opcode;
            w_sel_op_a   = req1_op_a;
            w_sel_op_b   = req1_op_b;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_wr_addr       <= '0;
            r_alloc_cnt     <= '0;
            r_commit_cnt    <= '0;
            r_prio          <= 1'b0;
            r_load_en       <= 1'b0;
            r_opcode        <= '0;
            r_operand_a     <= '0;
            r_operand_b     <= '0;
            r_rd_data_valid <= 1'b0;
            r_rd_data       <= '0;
        end else if (flush) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_wr_addr       <= '0;
            r_alloc_cnt     <= '0;
            r_commit_cnt    <= '0;
            r_prio          <= 1'b0;
            r_load_en       <= 1'b0;
            r_rd_data_valid <= 1'b0;
        end else begin
            r_load_en       <= w_acc;
            r_rd_data_valid <= w_rd_acc;
            if (w_acc) begin
                r_wr_addr   <= r_wr_ptr;
                r_wr_ptr    <= r_wr_ptr + 5'd1;
                r_opcode    <= w_sel_opcode;
                r_operand_a <= w_sel_op_a;
                r_operand_b <= w_sel_op_b;
                if (w_tie) begin
                    r_prio <= ~r_prio;
                end
            end
            if (w_rd_acc) begin
                r_rd_data <= instruction_word;
                r_rd_ptr  <= r_rd_ptr + 5'd1;
            end
            r_alloc_cnt  <= r_alloc_cnt  + 6'(w_acc)     - 6'(w_rd_acc);
            r_commit_cnt <= r_commit_cnt + 6'(r_load_en) - 6'(w_rd_acc);
        end
    end

    assign load_en       = r_load_en;
    assign write_pointer = r_wr_addr;
    assign read_pointer  = r_rd_ptr;
    assign opcode        = r_opcode;
    assign operand_a     = r_operand_a;
    assign operand_b     = r_operand_b;
    assign rd_data_valid = r_rd_data_valid;
    assign rd_data       = r_rd_data;

`ifdef INSTR_REG_CTRL_STATS_EN
    logic [15:0] r_stat_wr_cnt;
    logic [15:0] r_stat_full_cnt;

    // Saturating counters; flush deliberately leaves them alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_wr_cnt   <= '0;
            r_stat_full_cnt <= '0;
        end else begin
            if (w_acc && (r_stat_wr_cnt != 16'hFFFF)) begin
                r_stat_wr_cnt <= r_stat_wr_cnt + 16'd1;
            end
            if (w_full && (req0_valid || req1_valid) && (r_stat_full_cnt != 16'hFFFF)) begin
                r_stat_full_cnt <= r_stat_full_cnt + 16'd1;
            end
        end
    end

    assign stat_wr_cnt   = r_stat_wr_cnt;
    assign stat_full_cnt = r_stat_full_cnt;
`else
    assign stat_wr_cnt   = 16'd0;
    assign stat_full_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_instr_reg_ctrl.sv
// Scoreboard bench for instr_reg_ctrl: a queue-based reference model predicts
// grants, writes and reads; a monitor compares load and read-back traffic.
module tb_instr_reg_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, rd_valid, flush;
    logic        req0_ready, req1_ready, rd_ready, rd_data_valid, load_en;
    logic [3:0]  req0_opcode, req1_opcode, opcode;
    logic [31:0] req0_op_a, req0_op_b, req1_op_a, req1_op_b, operand_a, operand_b;
    logic [67:0] rd_data, instruction_word;
    logic [4:0]  write_pointer, read_pointer;
    logic [15:0] stat_wr_cnt, stat_full_cnt;

    always #5 clk = ~clk;

    instr_reg_ctrl dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_op_a(req0_op_a), .req0_op_b(req0_op_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_op_a(req1_op_a), .req1_op_b(req1_op_b),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data_valid(rd_data_valid),
        .rd_data(rd_data), .load_en(load_en), .write_pointer(write_pointer),
        .read_pointer(read_pointer), .opcode(opcode), .operand_a(operand_a),
        .operand_b(operand_b), .instruction_word(instruction_word), .flush(flush),
        .stat_wr_cnt(stat_wr_cnt), .stat_full_cnt(stat_full_cnt)
    );

    // External instruction register driven by the DUT's write port.
    logic [67:0] mem [32];
    always @(posedge clk) if (load_en) mem[write_pointer] <= {opcode, operand_a, operand_b};
    assign instruction_word = mem[read_pointer];

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of entries in accept order plus occupancy and stats.
    typedef struct { logic [4:0] wp; logic [67:0] data; } load_t;
    logic [67:0] mq[$];
    load_t       load_q[$];
    logic [67:0] rd_q[$];
    int          m_alloc, m_commit, m_pend, m_prio, m_wr_ptr, m_rd_ptr, m_last_wp;
    int          m_stat_wr, m_stat_full;

    task automatic model_clear(input bit with_stats);
        mq.delete();
        m_alloc = 0; m_commit = 0; m_pend = 0; m_prio = 0;
        m_wr_ptr = 0; m_rd_ptr = 0; m_last_wp = 0;
        if (with_stats) begin
            m_stat_wr = 0; m_stat_full = 0;
            load_q.delete(); rd_q.delete();
        end
    endtask

    // One clock cycle: check state-dependent outputs on the falling edge, then
    // advance the model across the coming rising edge.
    task automatic step();
        bit full, er0, er1, erd, acc, racc;
        logic [67:0] d;
        @(negedge clk);
        full = (m_alloc == 32);
        er0  = req0_valid && (!req1_valid || m_prio == 0) && !full && !flush;
        er1  = req1_valid && (!req0_valid || m_prio == 1) && !full && !flush;
        erd  = (m_commit != 0) && !flush;
        check("req0_ready", 68'(req0_ready), 68'(er0));
        check("req1_ready", 68'(req1_ready), 68'(er1));
        check("rd_ready", 68'(rd_ready), 68'(erd));
        check("read_pointer", 68'(read_pointer), 68'(m_rd_ptr));
        check("write_pointer", 68'(write_pointer), 68'(m_last_wp));
`ifdef INSTR_REG_CTRL_STATS_EN
        check("stat_wr_cnt", 68'(stat_wr_cnt), 68'(m_stat_wr));
        check("stat_full_cnt", 68'(stat_full_cnt), 68'(m_stat_full));
`else
        check("stat_wr_cnt", 68'(stat_wr_cnt), 68'(0));
        check("stat_full_cnt", 68'(stat_full_cnt), 68'(0));
`endif
        acc  = er0 || er1;
        racc = rd_valid && erd;
        if (acc && m_stat_wr < 65535) m_stat_wr++;
        if (full && (req0_valid || req1_valid) && m_stat_full < 65535) m_stat_full++;
        if (flush) begin
            model_clear(1'b0);
        end else begin
            if (acc) begin
                d = er1 ? {req1_opcode, req1_op_a, req1_op_b} : {req0_opcode, req0_op_a, req0_op_b};
                mq.push_back(d);
                load_q.push_back('{wp: 5'(m_wr_ptr), data: d});
                m_last_wp = m_wr_ptr;
                m_wr_ptr  = (m_wr_ptr + 1) % 32;
                if (req0_valid && req1_valid) m_prio = 1 - m_prio;
            end
            if (racc && mq.size() > 0) begin
                rd_q.push_back(mq.pop_front());
                m_rd_ptr = (m_rd_ptr + 1) % 32;
            end
            m_alloc  = m_alloc + int'(acc) - int'(racc);
            m_commit = m_commit + m_pend - int'(racc);
            m_pend   = int'(acc);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every load pulse and every read result is matched against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (load_en) begin
                if (load_q.size() == 0) begin
                    check("load_en_unexpected", 68'(load_en), 68'(0));
                end else begin
                    load_t it;
                    it = load_q.pop_front();
                    check("load_write_pointer", 68'(write_pointer), 68'(it.wp));
                    check("load_data", {opcode, operand_a, operand_b}, it.data);
                end
            end
            if (rd_data_valid) begin
                if (rd_q.size() == 0) check("rd_data_valid_unexpected", 68'(rd_data_valid), 68'(0));
                else check("rd_data", rd_data, rd_q.pop_front());
            end
        end
    end

    task automatic drive(input bit v0, input bit v1, input bit rv, input bit fl);
        req0_valid  = v0;               req1_valid  = v1;
        req0_opcode = 4'($urandom);     req1_opcode = 4'($urandom);
        req0_op_a   = $urandom;         req0_op_b   = $urandom;
        req1_op_a   = $urandom;         req1_op_b   = $urandom;
        rd_valid    = rv;               flush       = fl;
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_load_en"}, 68'(load_en), 68'(0));
        check({tag, "_write_pointer"}, 68'(write_pointer), 68'(0));
        check({tag, "_read_pointer"}, 68'(read_pointer), 68'(0));
        check({tag, "_instr_out"}, {opcode, operand_a, operand_b}, 68'(0));
        check({tag, "_rd_data"}, rd_data, 68'(0));
        check({tag, "_rd_data_valid"}, 68'(rd_data_valid), 68'(0));
        check({tag, "_rd_ready"}, 68'(rd_ready), 68'(0));
        check({tag, "_stats"}, 68'({stat_wr_cnt, stat_full_cnt}), 68'(0));
    endtask

    // Called just after a rising edge; reset asserts between edges.
    task automatic apply_reset(input string tag);
        reset = 1'b1;
        #1;
        check_reset_outputs(tag);
        model_clear(1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0; rd_valid = 0; flush = 0;
        req0_opcode = 0; req1_opcode = 0;
        req0_op_a = 0; req0_op_b = 0; req1_op_a = 0; req1_op_b = 0;
        model_clear(1'b1);
        #2;
        check_reset_outputs("por");
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Single write then read-back of {1, -5, 7}.
        req0_valid = 1; req0_opcode = 4'd1; req0_op_a = -32'sd5; req0_op_b = 32'sd7;
        step();
        req0_valid = 0;
        step();
        step();
        rd_valid = 1;
        step();
        rd_valid = 0;
        step(); step();

        // Both requesters valid for 4 cycles: alternating grants, then drain.
        repeat (4) drive(1, 1, 0, 0);
        repeat (6) drive(0, 0, 1, 0);

        // Fill to 32, stall, read+write in one cycle, then write accepted next cycle.
        repeat (32) drive(1, 0, 0, 0);
        step();
        repeat (3) drive(1, 1, 0, 0);
        drive(1, 0, 1, 0);
        drive(1, 0, 0, 0);
        repeat (36) drive(0, 0, 1, 0);

        // 40 write/read pairs across the pointer wrap.
        repeat (40) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 0);
        repeat (4) drive(0, 0, 1, 0);

        // Reset while a write is in flight: the load pulse must vanish.
        drive(1, 0, 0, 0);
        req0_valid = 0;
        check("pre_reset_load_en", 68'(load_en), 68'(1));
        apply_reset("midop");
        repeat (3) drive(0, 0, 0, 0);

        // Flush with 5 committed entries.
        repeat (5) drive(1, 0, 0, 0);
        repeat (2) drive(0, 0, 0, 0);
        drive(0, 0, 1, 1);
        drive(0, 0, 1, 0);
        check("flush_stat_wr", 68'(stat_wr_cnt),
`ifdef INSTR_REG_CTRL_STATS_EN
              68'(5));
`else
              68'(0));
`endif

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 60),
                  1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 99) < 2));
        end
        repeat (40) drive(0, 0, 1, 0);
        repeat (3) drive(0, 0, 0, 0);
        check("load_q_drained", 68'(load_q.size()), 68'(0));
        check("rd_q_drained", 68'(rd_q.size()), 68'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
